// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between writeback and a long-latency FIFO
module rf_write_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  query_rs1,
    input  logic [4:0]  query_rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        wb_stall,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_din,
    output logic        protocol_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    logic [4:0]    mem_rd   [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [WW-1:0] wait_cnt;
    logic [31:0]   pending, pending_nxt;
    logic [4:0]    head_rd;
    logic          wb_req, head_req, pop, push, head_we, violation;

    always_comb begin
        head_rd   = mem_rd[rd_ptr];
        wb_req    = wb_valid && wb_rd != '0;
        head_req  = count != '0;
        pop       = head_req && !wb_req;
        head_we   = pop && head_rd != '0;
        lu_ready  = count != FULL;
        push      = lu_valid && lu_ready;
        rf_we     = reset && (wb_req || head_we);
        rf_rd     = wb_req ? wb_rd : head_rd;
        rf_din    = wb_req ? wb_data : mem_data[rd_ptr];
        wb_stall  = wait_cnt == WMAX && head_req;
        rs1_busy  = pending[query_rs1];
        rs2_busy  = pending[query_rs2];
        violation = (issue_valid && issue_rd != '0 && pending[issue_rd]) ||
                    (wb_req && pending[wb_rd]) ||
                    (lu_valid && lu_rd != '0 && !pending[lu_rd]) ||
                    (wb_valid && wb_stall);
        // set after clear so a same-cycle reissue keeps the register pending
        pending_nxt = pending;
        if (head_we) pending_nxt[head_rd] = 1'b0;
        if (issue_valid && issue_rd != '0) pending_nxt[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= lu_rd;
            mem_data[wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            wait_cnt     <= '0;
            pending      <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            wait_cnt <= (!head_req || pop) ? '0 : (wait_cnt != WMAX) ? wait_cnt + 1'b1 : wait_cnt;
            pending  <= pending_nxt;
            if (violation) protocol_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: vector table, corner-case sequences and randomized queue-model checks
module tb_rf_write_arbiter;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0, reset = 1'b0;
    logic        wb_valid, lu_valid, issue_valid;
    logic [4:0]  wb_rd, lu_rd, issue_rd, query_rs1, query_rs2;
    logic [31:0] wb_data, lu_data;
    logic        lu_ready, rs1_busy, rs2_busy, wb_stall, rf_we, protocol_err;
    logic [4:0]  rf_rd;
    logic [31:0] rf_din;

    rf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .wb_stall(wb_stall),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_din(rf_din), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;
    ent_t      q[$];
    bit [31:0] pend;
    int        wcnt;
    bit        merr;

    typedef struct {
        logic        wv; logic [4:0] wr; logic [31:0] wd;
        logic        lv; logic [4:0] lr; logic [31:0] ld;
        logic        iv; logic [4:0] ir; logic [4:0] q1; logic [4:0] q2;
        logic        we; logic [4:0] rd; logic [31:0] din;
        logic        rdy; logic stall; logic b1; logic b2; logic err;
    } vec_t;
    vec_t tv[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                          input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                          input logic iv, input logic [4:0] ir, input logic [4:0] q1, input logic [4:0] q2);
        wb_valid = wv; wb_rd = wr; wb_data = wd;
        lu_valid = lv; lu_rd = lr; lu_data = ld;
        issue_valid = iv; issue_rd = ir; query_rs1 = q1; query_rs2 = q2;
    endtask

    task automatic idle(input logic [4:0] q1 = 0, input logic [4:0] q2 = 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, q1, q2);
    endtask

    task automatic model_reset;
        q.delete();
        pend = '0;
        wcnt = 0;
        merr = 0;
    endtask

    // advance the reference model by one clock edge using the inputs currently applied
    task automatic model_step;
        bit wbr, head, pop, push, stall;
        wbr   = wb_valid && wb_rd != 0;
        head  = q.size() > 0;
        pop   = head && !wbr;
        push  = lu_valid && q.size() < DEPTH;
        stall = head && wcnt == MAX_WAIT;
        if ((issue_valid && issue_rd != 0 && pend[issue_rd]) || (wbr && pend[wb_rd]) ||
            (lu_valid && lu_rd != 0 && !pend[lu_rd]) || (wb_valid && stall)) merr = 1;
        if (!head || pop) wcnt = 0;
        else if (wcnt < MAX_WAIT) wcnt++;
        if (pop && q[0].rd != 0) pend[q[0].rd] = 0;
        if (issue_valid && issue_rd != 0) pend[issue_rd] = 1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{lu_rd, lu_data});
    endtask

    task automatic model_check;
        bit wbr, head, ewe;
        wbr  = wb_valid && wb_rd != 0;
        head = q.size() > 0;
        ewe  = wbr || (head && q[0].rd != 0);
        chk("rand_we", rf_we, ewe);
        if (wbr) begin
            chk("rand_rd", rf_rd, wb_rd);
            chk("rand_din", rf_din, wb_data);
        end else if (ewe) begin
            chk("rand_rd", rf_rd, q[0].rd);
            chk("rand_din", rf_din, q[0].d);
        end
        chk("rand_ready", lu_ready, q.size() < DEPTH);
        chk("rand_stall", wb_stall, head && wcnt == MAX_WAIT);
        chk("rand_busy1", rs1_busy, pend[query_rs1]);
        chk("rand_busy2", rs2_busy, pend[query_rs2]);
        chk("rand_err", protocol_err, merr);
    endtask

    task automatic step;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        idle();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // blocked FIFO head starves; keep=1 ignores the stall and keeps writing back
    task automatic starve(input bit keep);
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 8, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 1, 9, 0, 0); step();
        set_in(1, 3, 32'h333, 1, 8, 32'h888, 0, 0, 8, 9);
        @(negedge clk);
        chk("stv_wb_we", rf_we, 1);
        chk("stv_wb_rd", rf_rd, 3);
        chk("stv_ready0", lu_ready, 1);
        step();
        set_in(1, 3, 32'h333, 1, 9, 32'h999, 0, 0, 8, 9);
        @(negedge clk);
        chk("stv_ready1", lu_ready, 1);
        chk("stv_busy", rs1_busy, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 3, 32'h333, 0, 0, 0, 0, 0, 8, 9);
            @(negedge clk);
            chk("stv_full", lu_ready, 0);
            chk("stv_nostall", wb_stall, 0);
            step();
        end
        if (keep) set_in(1, 3, 32'h333, 0, 0, 0, 0, 0, 8, 9);
        else idle(8, 9);
        @(negedge clk);
        chk("stv_stall", wb_stall, 1);
        chk("stv_full_pop", lu_ready, 0);
        chk("stv_we", rf_we, 1);
        chk("stv_rd", rf_rd, keep ? 5'd3 : 5'd8);
        chk("stv_din", rf_din, keep ? 32'h333 : 32'h888);
        step();
        idle(8, 9);
        @(negedge clk);
        chk("stv_stall_next", wb_stall, keep);
        chk("stv_err", protocol_err, keep);
        chk("stv_we2", rf_we, 1);
        chk("stv_rd2", rf_rd, keep ? 5'd8 : 5'd9);
        chk("stv_busy8", rs1_busy, keep);
        step();
        @(negedge clk);
        chk("stv_err_sticky", protocol_err, keep);
        chk("stv_busy9", rs2_busy, keep);
        step();
    endtask

    initial begin
        idle();
        tv[0] = '{0, 0, 0,            0, 0, 0,        0, 0, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0};
        tv[1] = '{1, 5, 32'hA5A5A5A5, 0, 0, 0,        0, 0, 0, 0, 1, 5, 32'hA5A5A5A5, 1, 0, 0, 0, 0};
        tv[2] = '{0, 0, 0,            0, 0, 0,        1, 7, 7, 0, 0, 0, 0,            1, 0, 0, 0, 0};
        tv[3] = '{0, 0, 0,            0, 0, 0,        0, 0, 7, 7, 0, 0, 0,            1, 0, 1, 1, 0};
        tv[4] = '{0, 0, 0,            0, 0, 0,        0, 0, 7, 0, 0, 0, 0,            1, 0, 1, 0, 0};
        tv[5] = '{0, 0, 0,            1, 7, 32'h1234, 0, 0, 7, 0, 0, 0, 0,            1, 0, 1, 0, 0};
        tv[6] = '{0, 0, 0,            0, 0, 0,        0, 0, 7, 0, 1, 7, 32'h1234,     1, 0, 1, 0, 0};
        tv[7] = '{0, 0, 0,            0, 0, 0,        0, 0, 7, 0, 0, 0, 0,            1, 0, 0, 0, 0};
        tv[8] = '{1, 0, 32'hFFFFFFFF, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0};
        tv[9] = '{1, 7, 32'hDEAD,     0, 0, 0,        0, 0, 7, 0, 1, 7, 32'hDEAD,     1, 0, 0, 0, 0};

        do_reset();
        foreach (tv[i]) begin
            set_in(tv[i].wv, tv[i].wr, tv[i].wd, tv[i].lv, tv[i].lr, tv[i].ld,
                   tv[i].iv, tv[i].ir, tv[i].q1, tv[i].q2);
            @(negedge clk);
            chk($sformatf("vec%0d_we", i), rf_we, tv[i].we);
            if (tv[i].we) begin
                chk($sformatf("vec%0d_rd", i), rf_rd, tv[i].rd);
                chk($sformatf("vec%0d_din", i), rf_din, tv[i].din);
            end
            chk($sformatf("vec%0d_ready", i), lu_ready, tv[i].rdy);
            chk($sformatf("vec%0d_stall", i), wb_stall, tv[i].stall);
            chk($sformatf("vec%0d_busy1", i), rs1_busy, tv[i].b1);
            chk($sformatf("vec%0d_busy2", i), rs2_busy, tv[i].b2);
            chk($sformatf("vec%0d_err", i), protocol_err, tv[i].err);
            step();
        end

        starve(0);
        starve(1);

        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 7, 0, 0); step();
        @(negedge clk);
        chk("issue_ok_err", protocol_err, 0);
        set_in(0, 0, 0, 0, 0, 0, 1, 7, 0, 0); step();
        @(negedge clk);
        chk("reissue_err", protocol_err, 1);

        do_reset();
        set_in(1, 9, 32'h99, 0, 0, 0, 1, 9, 0, 0); step();
        @(negedge clk);
        chk("set_then_wb_err", protocol_err, 0);
        set_in(1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0); step();
        @(negedge clk);
        chk("waw_err", protocol_err, 1);

        do_reset();
        set_in(0, 0, 0, 1, 12, 32'hC, 0, 0, 0, 0); step();
        @(negedge clk);
        chk("lu_unpending_err", protocol_err, 1);

        // reset dropped mid-cycle with two buffered results and pending bits set
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 8, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 1, 9, 0, 0); step();
        set_in(1, 3, 32'h333, 1, 8, 32'h888, 0, 0, 8, 9); step();
        set_in(1, 3, 32'h333, 1, 9, 32'h999, 0, 0, 8, 9); step();
        @(negedge clk);
        chk("pre_rst_full", lu_ready, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_we", rf_we, 0);
        chk("rst_ready", lu_ready, 1);
        chk("rst_busy1", rs1_busy, 0);
        chk("rst_busy2", rs2_busy, 0);
        chk("rst_stall", wb_stall, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        idle(8, 9);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_we", rf_we, 0);
            chk("post_rst_ready", lu_ready, 1);
            chk("post_rst_busy", rs1_busy | rs2_busy, 0);
            chk("post_rst_err", protocol_err, 0);
            step();
        end

        // legal random traffic first, then unconstrained traffic
        for (int phase = 0; phase < 2; phase++) begin
            do_reset();
            for (int n = 0; n < 3000; n++) begin
                logic [4:0] r;
                wb_valid    = $urandom_range(0, 9) < 4;
                wb_rd       = 5'($urandom_range(0, 15));
                wb_data     = $urandom;
                lu_valid    = $urandom_range(0, 9) < 4;
                lu_rd       = 5'($urandom_range(0, 15));
                lu_data     = $urandom;
                issue_valid = $urandom_range(0, 9) < 3;
                issue_rd    = 5'($urandom_range(0, 15));
                r           = 5'($urandom_range(0, 15));
                query_rs1   = r;
                query_rs2   = 5'($urandom_range(0, 31));
                if (phase == 0) begin
                    if (pend[wb_rd] || (q.size() > 0 && wcnt == MAX_WAIT)) wb_valid = 0;
                    if (pend[issue_rd]) issue_valid = 0;
                    if (lu_rd == 0 || !pend[lu_rd]) lu_valid = 0;
                end
                @(negedge clk);
                model_check();
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback stage and a long-latency unit (multiplier/divider).
- Buffers long-latency results in a small FIFO and keeps a pending-destination scoreboard that feeds hazard detection.
- Drives write_enable/rd/rd_din of the register file directly, in the same cycle.
- Forces a one-cycle writeback hold when the long-latency result has been starved for too long.

Parameters:
- DEPTH, 2, long-latency result FIFO entries (power of two, ≥2)
- MAX_WAIT, 4, cycles a FIFO head may wait ungranted before wb_stall asserts (≥1)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- wb_valid  in  1  pipeline writeback wants to write (RegWrite)
- wb_rd  in  5  pipeline destination register
- wb_data  in  32  pipeline write data
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept a result
- lu_rd  in  5  long-latency destination register
- lu_data  in  32  long-latency result data
- issue_valid  in  1  long-latency op issued this cycle
- issue_rd  in  5  destination of issued op
- query_rs1  in  5  hazard query, source 1
- query_rs2  in  5  hazard query, source 2
- rs1_busy  out  1  query_rs1 has an outstanding long-latency write
- rs2_busy  out  1  query_rs2 has an outstanding long-latency write
- wb_stall  out  1  pipeline must present wb_valid=0 this cycle
- rf_we  out  1  register file write enable
- rf_rd  out  5  register file destination
- rf_din  out  32  register file write data
- protocol_err  out  1  sticky contract-violation flag

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty; all 32 pending bits cleared; wait counter 0; protocol_err 0.
  - Outputs during reset: rf_we=0, lu_ready=1, wb_stall=0, rs1_busy=rs2_busy=0.
  - Reset mid-operation discards buffered results without writing them.
- Write-port grant (combinational from inputs and registered state):
  - wb_req = wb_valid && wb_rd!=0; head_req = FIFO non-empty.
  - If wb_req: rf_we=1, rf_rd=wb_rd, rf_din=wb_data. WB always wins, even while wb_stall=1 (no data loss).
  - Else if head_req: rf_we=1 with head rd/data; the head pops at the clock edge.
  - Else rf_we=0.
  - wb_valid with wb_rd=0 counts as no request; the port is free for the FIFO.
- FIFO:
  - lu_ready = !full.
  - Enqueue on lu_valid && lu_ready; lu_rd=0 entries are accepted but pop without asserting rf_we.
  - No same-cycle bypass: a result accepted at edge N is written in cycle N+1 at the earliest.
  - Simultaneous pop and push: count unchanged.
  - Full: lu_ready=0, even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH.
- Starvation:
  - wait_cnt increments each cycle head_req && wb_req; clears on a head pop or empty FIFO; saturates at MAX_WAIT.
  - wb_stall = (wait_cnt==MAX_WAIT) && head_req, decoded from registered state only.
  - wb_valid=1 while wb_stall=1 sets protocol_err.
- Scoreboard:
  - issue_valid && issue_rd!=0 sets pending[issue_rd].
  - A head pop with rf_we=1 clears pending[head rd].
  - Set and clear of the same register in one cycle: set wins.
  - rsN_busy = pending[query_rsN]; always 0 for x0.
- Contract checks (each sets protocol_err; cleared only by reset):
  - issue_rd already pending.
  - wb_req to a pending register (WAW).
  - lu_valid with lu_rd whose pending bit is 0 (lu_rd!=0).
  - wb_valid=1 while wb_stall=1.

Test Plan:
- Reset, then idle -> rf_we=0, lu_ready=1, wb_stall=0, busy=0.
- wb_valid=1, wb_rd=5, wb_data=0xA5A5A5A5 -> same cycle rf_we=1, rf_rd=5, rf_din=0xA5A5A5A5.
- issue_rd=7 at cycle 0 -> rs1_busy=1 for query_rs1=7. lu result rd=7, data=0x1234 accepted at cycle 3, wb idle -> cycle 4: rf_we=1, rf_rd=7. Cycle 5: rs1_busy=0.
- Fill FIFO with rd=8, rd=9 while wb_valid held with rd=3 -> lu_ready=0 after 2 accepts. After MAX_WAIT=4 blocked cycles, wb_stall=1. Bench drops wb_valid -> rd=8 written, wb_stall=0 next cycle.
- wb_valid=1 while wb_stall=1 -> WB still written, protocol_err=1 and stays 1. issue_rd=7 while 7 pending -> protocol_err=1.
- FIFO holding 2 entries with pending bits set, then reset pulled low mid-cycle -> rf_we=0 immediately; after release, empty, lu_ready=1, all busy=0, no write of dropped data.
